// File: rtl/sram_port_arb.sv
// Two-port burst arbiter in front of a banked single-port SRAM.
// Round-robin on whole bursts; at most one SRAM access per cycle.
module sram_port_arb #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [LEN_WIDTH-1:0]  req0_len,
  input  logic                  stall0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [3:0]            wstrb0,
  output logic                  grant0,
  output logic                  rvalid0,
  output logic                  done0,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [LEN_WIDTH-1:0]  req1_len,
  input  logic                  stall1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [3:0]            wstrb1,
  output logic                  grant1,
  output logic                  rvalid1,
  output logic                  done1,

  output logic [DATA_WIDTH-1:0] rdata,
  output logic [12:0]           sram_addr_out,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  sram_wen,
  output logic [3:0]            bank0_csn,
  output logic [3:0]            bank1_csn,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  // state | meaning
  // IDLE  | no owner; accept one pending request per cycle
  // BURST | owner issues one beat per unstalled cycle until counter == len
  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  CNT_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic                  last_grant;
  logic                  owner;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  rv0_q, rv1_q;

  logic                  any_req, sel, accept;
  logic                  stall_cur, beat, last_beat;
  logic [3:0]            wstrb_cur, lane_csn;
  logic [DATA_WIDTH-1:0] wdata_cur;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    any_req   = req0_valid | req1_valid;
    // on a tie the port that did not win last time goes first
    sel       = !req0_valid ? 1'b1 : (req1_valid ? ~last_grant : 1'b0);
    accept    = ARESETn && (state == IDLE) && any_req;
    stall_cur = owner ? stall1 : stall0;
    wstrb_cur = owner ? wstrb1 : wstrb0;
    wdata_cur = owner ? wdata1 : wdata0;
    beat      = (state == BURST) && !stall_cur;
    last_beat = beat && (cnt_q == len_q);

    state_nxt = state;
    if (accept)    state_nxt = BURST;
    if (last_beat) state_nxt = IDLE;

    req0_ready = accept && !sel;
    req1_ready = accept && sel;
    grant0     = (state == BURST) && !owner;
    grant1     = (state == BURST) && owner;
    done0      = last_beat && !owner;
    done1      = last_beat && owner;

    // all-zero strobe still consumes a beat but selects no lane
    lane_csn      = wr_q ? ~wstrb_cur : 4'h0;
    sram_wen      = !(beat && wr_q);
    sram_addr_out = beat ? addr_q[12:0] : 13'h0;
    sram_wdata    = (beat && wr_q) ? wdata_cur : '0;
    bank0_csn     = (beat && !addr_q[ADDR_WIDTH-1]) ? lane_csn : 4'hF;
    bank1_csn     = (beat &&  addr_q[ADDR_WIDTH-1]) ? lane_csn : 4'hF;

    rvalid0 = rv0_q;
    rvalid1 = rv1_q;
    rdata   = (rv0_q | rv1_q) ? sram_rdata : '0;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
    end else begin
      rv0_q <= beat && !wr_q && !owner;
      rv1_q <= beat && !wr_q && owner;
      if (accept) begin
        last_grant <= sel;
        owner      <= sel;
        wr_q       <= sel ? req1_write : req0_write;
        addr_q     <= sel ? req1_addr  : req0_addr;
        len_q      <= sel ? req1_len   : req0_len;
        cnt_q      <= '0;
      end else if (beat) begin
        addr_q <= addr_q + ADDR_ONE;
        cnt_q  <= cnt_q + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed bench for sram_port_arb: inputs change #1 after the rising edge,
// outputs are checked #1 later with hand-computed expectations.
module tb_sram_port_arb;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        req0_valid, req0_ready, req0_write;
  logic [13:0] req0_addr;
  logic [7:0]  req0_len;
  logic        stall0;
  logic [31:0] wdata0;
  logic [3:0]  wstrb0;
  logic        grant0, rvalid0, done0;
  logic        req1_valid, req1_ready, req1_write;
  logic [13:0] req1_addr;
  logic [7:0]  req1_len;
  logic        stall1;
  logic [31:0] wdata1;
  logic [3:0]  wstrb1;
  logic        grant1, rvalid1, done1;
  logic [31:0] rdata, sram_wdata, sram_rdata;
  logic [12:0] sram_addr_out;
  logic        sram_wen;
  logic [3:0]  bank0_csn, bank1_csn;

  int passed = 0;
  int total  = 0;

  sram_port_arb dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_len(req0_len), .stall0(stall0),
    .wdata0(wdata0), .wstrb0(wstrb0), .grant0(grant0), .rvalid0(rvalid0), .done0(done0),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_len(req1_len), .stall1(stall1),
    .wdata1(wdata1), .wstrb1(wstrb1), .grant1(grant1), .rvalid1(rvalid1), .done1(done1),
    .rdata(rdata), .sram_addr_out(sram_addr_out), .sram_wdata(sram_wdata),
    .sram_wen(sram_wen), .bank0_csn(bank0_csn), .bank1_csn(bank1_csn),
    .sram_rdata(sram_rdata)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  // checks the shared SRAM bus in one call
  task automatic chk_bus(input string tag, input logic [12:0] a, input logic wen,
                         input logic [3:0] c0, input logic [3:0] c1);
    chk({tag, ".addr"}, {19'h0, sram_addr_out}, {19'h0, a});
    chk({tag, ".wen"},  {31'h0, sram_wen},      {31'h0, wen});
    chk({tag, ".csn0"}, {28'h0, bank0_csn},     {28'h0, c0});
    chk({tag, ".csn1"}, {28'h0, bank1_csn},     {28'h0, c1});
  endtask

  initial begin
    logic [12:0] rows [4];
    rows[0] = 13'h1FFE; rows[1] = 13'h1FFF; rows[2] = 13'h0000; rows[3] = 13'h0001;

    ARESETn = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = '0; req0_len = '0;
    stall0 = 1'b0; wdata0 = '0; wstrb0 = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_len = '0;
    stall1 = 1'b0; wdata1 = '0; wstrb1 = '0;
    sram_rdata = 32'hDEADBEEF;
    #2;
    // reset state, even with a request pending
    chk("rst.ready0", {31'h0, req0_ready}, 32'h0);
    chk("rst.grant0", {31'h0, grant0}, 32'h0);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.wdata", sram_wdata, 32'h0);
    chk_bus("rst", 13'h0, 1'b1, 4'hF, 4'hF);
    req0_valid = 1'b0;
    tick; tick;
    ARESETn = 1'b1;
    tick;

    // tie after reset: port 0 first, then port 1, one IDLE cycle between
    req0_valid = 1'b1; req0_addr = 14'h0100; req0_len = 8'd0;
    req1_valid = 1'b1; req1_addr = 14'h0200; req1_len = 8'd0;
    #1;
    chk("tie1.ready0", {31'h0, req0_ready}, 32'h1);
    chk("tie1.ready1", {31'h0, req1_ready}, 32'h0);
    tick;
    req0_valid = 1'b0; #1;
    chk("tie1.grant0", {31'h0, grant0}, 32'h1);
    chk("tie1.done0", {31'h0, done0}, 32'h1);
    chk("tie1.ready1_busy", {31'h0, req1_ready}, 32'h0);
    chk_bus("tie1.b0", 13'h0100, 1'b1, 4'h0, 4'hF);
    tick;
    chk("tie1.gap_ready1", {31'h0, req1_ready}, 32'h1);
    chk("tie1.gap_grant0", {31'h0, grant0}, 32'h0);
    chk("tie1.rvalid0", {31'h0, rvalid0}, 32'h1);
    chk_bus("tie1.gap", 13'h0, 1'b1, 4'hF, 4'hF);
    tick;
    req1_valid = 1'b0; #1;
    chk("tie1.grant1", {31'h0, grant1}, 32'h1);
    chk("tie1.done1", {31'h0, done1}, 32'h1);
    chk("tie1.rvalid0_once", {31'h0, rvalid0}, 32'h0);
    chk_bus("tie1.b1", 13'h0200, 1'b1, 4'h0, 4'hF);
    tick;
    chk("tie1.rvalid1", {31'h0, rvalid1}, 32'h1);
    chk("tie1.done1_once", {31'h0, done1}, 32'h0);
    tick;

    // port 0 write burst across the bank boundary
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 14'h1FFE; req0_len = 8'd3; wstrb0 = 4'hF;
    #1;
    chk("wr4.ready0", {31'h0, req0_ready}, 32'h1);
    tick;
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wdata0 = 32'hD000_0000 + i;
      #1;
      chk_bus($sformatf("wr4.b%0d", i), rows[i], 1'b0, (i < 2) ? 4'h0 : 4'hF, (i < 2) ? 4'hF : 4'h0);
      chk($sformatf("wr4.wdata%0d", i), sram_wdata, 32'hD000_0000 + i);
      chk($sformatf("wr4.done%0d", i), {31'h0, done0}, (i == 3) ? 32'h1 : 32'h0);
      tick;
    end
    chk("wr4.end_grant0", {31'h0, grant0}, 32'h0);
    chk("wr4.no_rvalid", {31'h0, rvalid0}, 32'h0);

    // tie with last_grant=0: port 1 read wins, port 0 write stays pending
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 14'h2005; req0_len = 8'd0;
    wstrb0 = 4'b0101; wdata0 = 32'hCAFEF00D;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 14'h0010; req1_len = 8'd2;
    #1;
    chk("tie2.ready1", {31'h0, req1_ready}, 32'h1);
    chk("tie2.ready0", {31'h0, req0_ready}, 32'h0);
    tick;
    req1_valid = 1'b0; stall1 = 1'b0; #1;
    chk("rd.grant1", {31'h0, grant1}, 32'h1);
    chk("rd.ready0_busy", {31'h0, req0_ready}, 32'h0);
    chk_bus("rd.b0", 13'h0010, 1'b1, 4'h0, 4'hF);
    tick;
    stall1 = 1'b1; sram_rdata = 32'h11112222; #1;
    chk("rd.rvalid_a", {31'h0, rvalid1}, 32'h1);
    chk("rd.rdata_a", rdata, 32'h11112222);
    chk("rd.stall_done", {31'h0, done1}, 32'h0);
    chk_bus("rd.stall", 13'h0, 1'b1, 4'hF, 4'hF);
    tick;
    stall1 = 1'b0; #1;
    chk("rd.rvalid_stall", {31'h0, rvalid1}, 32'h0);
    chk("rd.rdata_gated", rdata, 32'h0);
    chk_bus("rd.b1", 13'h0011, 1'b1, 4'h0, 4'hF);
    tick;
    sram_rdata = 32'h33334444; #1;
    chk("rd.rvalid_b", {31'h0, rvalid1}, 32'h1);
    chk("rd.rdata_b", rdata, 32'h33334444);
    chk("rd.done1", {31'h0, done1}, 32'h1);
    chk_bus("rd.b2", 13'h0012, 1'b1, 4'h0, 4'hF);
    tick;
    sram_rdata = 32'h55556666; #1;
    chk("rd.trail_rvalid", {31'h0, rvalid1}, 32'h1);
    chk("rd.trail_rdata", rdata, 32'h55556666);
    chk("rd.end_grant1", {31'h0, grant1}, 32'h0);
    chk("pend.ready0", {31'h0, req0_ready}, 32'h1);
    tick;

    // strobe 0101 on bank 1
    req0_valid = 1'b0; #1;
    chk_bus("strb", 13'h0005, 1'b0, 4'hF, 4'b1010);
    chk("strb.wdata", sram_wdata, 32'hCAFEF00D);
    chk("strb.done0", {31'h0, done0}, 32'h1);
    tick;
    chk("strb.no_rvalid", {31'h0, rvalid0}, 32'h0);

    // zero strobe still a beat
    req0_valid = 1'b1; req0_addr = 14'h0020; wstrb0 = 4'h0;
    tick;
    req0_valid = 1'b0; #1;
    chk_bus("z", 13'h0020, 1'b0, 4'hF, 4'hF);
    chk("z.done0", {31'h0, done0}, 32'h1);
    tick;

    // read wrapping 0x3FFF -> 0x0000
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 14'h3FFF; req1_len = 8'd1;
    tick;
    req1_valid = 1'b0; #1;
    chk_bus("wrap.b0", 13'h1FFF, 1'b1, 4'hF, 4'h0);
    tick;
    chk_bus("wrap.b1", 13'h0000, 1'b1, 4'h0, 4'hF);
    chk("wrap.done1", {31'h0, done1}, 32'h1);
    tick;

    // reset in the middle of a len=7 read at beat 3
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 14'h0040; req0_len = 8'd7;
    tick;
    req0_valid = 1'b0;
    tick; tick; tick;
    sram_rdata = 32'h77778888;
    ARESETn = 1'b0; #1;
    chk_bus("abort", 13'h0, 1'b1, 4'hF, 4'hF);
    chk("abort.grant0", {31'h0, grant0}, 32'h0);
    chk("abort.done0", {31'h0, done0}, 32'h0);
    chk("abort.rvalid0", {31'h0, rvalid0}, 32'h0);
    chk("abort.rdata", rdata, 32'h0);
    tick;
    ARESETn = 1'b1;
    tick;
    chk("norsm.grant0", {31'h0, grant0}, 32'h0);
    chk_bus("norsm", 13'h0, 1'b1, 4'hF, 4'hF);

    // fresh tie after reset goes to port 0 at its new address
    req0_valid = 1'b1; req0_addr = 14'h0100; req0_len = 8'd0;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 14'h0300; req1_len = 8'd0;
    #1;
    chk("post.ready0", {31'h0, req0_ready}, 32'h1);
    tick;
    req0_valid = 1'b0; #1;
    chk_bus("post.b0", 13'h0100, 1'b1, 4'h0, 4'hF);
    tick;
    tick;
    req1_valid = 1'b0; #1;
    chk_bus("post.b1", 13'h0300, 1'b1, 4'h0, 4'hF);
    tick; tick;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_port_arb.md
SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH 14 (word address: bit 13 = bank, bits 12:0 = SRAM row); DATA_WIDTH 32 (bank word, 4 byte lanes); LEN_WIDTH 8 (burst beats minus 1).
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports listed in this order:
- ACLK  in  1  clock, all state on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
REQ-003 SHALL provide, for each requester port N in {0,1}:
- reqN_valid  in  1  burst request.
- reqN_ready  out  1  burst accepted.
- reqN_write  in  1  1=write burst, 0=read burst.
- reqN_addr  in  ADDR_WIDTH  start word address.
- reqN_len  in  LEN_WIDTH  beats-1, INCR only.
- stallN  in  1  hold current beat (write data not ready / read sink busy).
- wdataN  in  DATA_WIDTH  write beat data.
- wstrbN  in  4  byte enables, 1=write lane.
- grantN  out  1  port N owns SRAM.
- rvalidN  out  1  read beat data valid on rdata.
- doneN  out  1  one-cycle pulse, last beat issued.
REQ-004 SHALL provide these shared ports:
- rdata  out  DATA_WIDTH  read data, passed through from sram_rdata.
- sram_addr_out  out  13  SRAM row.
- sram_wdata  out  DATA_WIDTH  write data to SRAM.
- sram_wen  out  1  active-low write enable.
- bank0_csn  out  4  active-low byte-lane selects, bank 0.
- bank1_csn  out  4  active-low byte-lane selects, bank 1.
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid one cycle after the access.

Function
REQ-005 SHALL use the FSM states IDLE and BURST, with one access to the SRAM per cycle at most.
REQ-006 In IDLE with any reqN_valid=1, the FSM SHALL assert reqN_ready (combinational) for the selected port only and go to BURST next cycle.
REQ-007 Arbitration SHALL be round-robin on whole bursts: if both ports request, the port != last_grant wins; a single requester always wins; last_grant updates on acceptance.
REQ-008 On acceptance, the block SHALL latch addr, len and write; clear beat counter; assert grantN from the next cycle until the cycle after the last beat.
REQ-009 In BURST, a beat SHALL issue in any cycle where stallN=0 for the granted port; in cycles with stallN=1 there is no access, all csn=4'hF and sram_wen=1.
REQ-010 On an issued beat, sram_addr_out SHALL be addr[12:0], and only the bank selected by addr[13] is driven; the other bank's csn SHALL be 4'hF.
REQ-011 A write beat SHALL drive: sram_wen=0; selected csn=~wstrbN; sram_wdata=wdataN.
REQ-012 A read beat SHALL drive: sram_wen=1; selected csn=4'h0.
REQ-013 A write beat with wstrbN=4'h0 SHALL still count as a beat, with all csn=4'hF.
REQ-014 After each beat, addr SHALL increment by 1 modulo 2^ADDR_WIDTH (16383 wraps to 0, crossing banks naturally), and the beat counter SHALL increment.
REQ-015 The beat issued with counter==len SHALL be last: doneN pulses in that same cycle, and the FSM returns to IDLE next cycle.
REQ-016 The earliest next-burst acceptance SHALL be the first IDLE cycle (one-cycle bus turnaround).
REQ-017 rvalidN SHALL be asserted exactly one cycle after each read beat of port N, with rdata=sram_rdata; there is no rvalid for write beats.
REQ-018 A trailing rvalid SHALL still fire after the FSM has left BURST.
REQ-019 reqN_valid changes during BURST SHALL be ignored; requests stay pending until accepted.
REQ-020 The default/idle outputs SHALL be: sram_wen=1; csn=4'hF; grant=0; sram_addr_out=0; sram_wdata=0.

Reset
REQ-021 ARESETn=0 SHALL, asynchronously and at any time including mid-burst, force: IDLE; last_grant=1 (port 0 wins first tie); all reqN_ready/grantN/rvalidN/doneN=0; sram_wen=1; bank0_csn=bank1_csn=4'hF; sram_addr_out=0; sram_wdata=0; rdata path output 0 via the rvalid gate.
REQ-022 An aborted burst SHALL NOT resume after reset release; the requester must re-request.

Verification
REQ-023 Reset, then both valid at the same time, both len=0 -> port 0 granted first, port 1 next; each done0/done1 pulses once; IDLE gap of one cycle between bursts.
REQ-024 Port 0 write, addr=0x1FFE, len=3, wstrb0=4'hF, no stall -> 4 beats: rows 0x1FFE/0x1FFF on bank0_csn=0, then rows 0x0000/0x0001 on bank1_csn=0; done0 on the 4th beat.
REQ-025 Port 1 read, addr=0x0010, len=2, stall1=1 on the 2nd beat cycle -> 3 beats across 4 cycles; rvalid1 three times, each 1 cycle after its beat; the stalled cycle has csn=4'hF.
REQ-026 Write with wstrb0=4'b0101, addr=0x2005 -> bank1_csn=4'b1010, bank0_csn=4'hF, sram_wen=0, sram_addr_out=0x0005.
REQ-027 Assert ARESETn=0 mid-way through a len=7 burst at beat 3 -> same-cycle csn=4'hF, wen=1, grant=0, no done pulse; after release, a new request starts at the requested address.
REQ-028 Addr=0x3FFF, len=1 -> second beat at addr 0x0000, bank 0.
